// File: rtl/rsa_core_mod.sv
// Restoring shift-subtract reducer: mod_r = mod_x mod mod_n, one dividend bit per clock.
// Optional RSA_MOD_FAST_EN: single-edge bypass when mod_x is already below mod_n.
module rsa_core_mod #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      mod_clk,
  input  logic                      mod_rst,
  input  logic                      mod_start,
  input  logic [2*DATA_WIDTH-1:0]   mod_x,
  input  logic [DATA_WIDTH-1:0]     mod_n,
  output logic                      mod_busy,
  output logic                      mod_done,
  output logic                      mod_err,
  output logic [DATA_WIDTH-1:0]     mod_r
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = (2 * W > 1) ? $clog2(2 * W) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [CW-1:0] LAST = CW'(2 * W - 1);

  logic [0:0]     state;
  logic [2*W-1:0] x_sh;
  logic [W-1:0]   n_q;
  logic [W:0]     r_acc;
  logic [CW-1:0]  cnt;

  logic [W:0]     t;
  logic [W:0]     r_next;
  logic           n_zero;
  logic           fast_ok;

  // Top bit of r_acc is always 0 between steps, so the shift drops nothing.
  always_comb begin
    t      = (r_acc << 1) | {{W{1'b0}}, x_sh[2*W-1]};
    r_next = (t >= {1'b0, n_q}) ? t - {1'b0, n_q} : t;
  end

  assign n_zero = (mod_n == '0);

`ifdef RSA_MOD_FAST_EN
  assign fast_ok = (mod_x[2*W-1:W] == '0) && (mod_x[W-1:0] < mod_n);
`else
  assign fast_ok = 1'b0;
`endif

  always_ff @(posedge mod_clk or posedge mod_rst) begin
    if (mod_rst) begin
      state    <= IDLE;
      mod_busy <= 1'b0;
      mod_done <= 1'b0;
      mod_err  <= 1'b0;
      mod_r    <= '0;
      x_sh     <= '0;
      n_q      <= '0;
      r_acc    <= '0;
      cnt      <= '0;
    end else begin
      mod_done <= 1'b0;
      mod_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mod_start) begin
            if (n_zero) begin
              mod_done <= 1'b1;
              mod_err  <= 1'b1;
              mod_r    <= '0;
            end else if (fast_ok) begin
              mod_r    <= mod_x[W-1:0];
              mod_done <= 1'b1;
            end else begin
              x_sh     <= mod_x;
              n_q      <= mod_n;
              r_acc    <= '0;
              cnt      <= '0;
              state    <= RUN;
              mod_busy <= 1'b1;
            end
          end
        end
        RUN: begin
          r_acc <= r_next;
          x_sh  <= x_sh << 1;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            mod_r    <= r_next[W-1:0];
            mod_done <= 1'b1;
            mod_busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_core_mod.sv
// Scoreboard bench for rsa_core_mod (W=8): result, error flag and latency
// are predicted at request time and compared on each mod_done pulse.
module tb_rsa_core_mod;

  localparam int W = 8;

  logic           mod_clk;
  logic           mod_rst;
  logic           mod_start;
  logic [2*W-1:0] mod_x;
  logic [W-1:0]   mod_n;
  logic           mod_busy;
  logic           mod_done;
  logic           mod_err;
  logic [W-1:0]   mod_r;

  typedef struct {
    logic [W-1:0] r;
    logic         err;
    int           e0;
    int           lat;
  } exp_t;

  exp_t q[$];
  int   n_vec;
  int   n_bad;
  int   edge_n;

  rsa_core_mod #(.DATA_WIDTH(W)) dut (
    .mod_clk   (mod_clk),
    .mod_rst   (mod_rst),
    .mod_start (mod_start),
    .mod_x     (mod_x),
    .mod_n     (mod_n),
    .mod_busy  (mod_busy),
    .mod_done  (mod_done),
    .mod_err   (mod_err),
    .mod_r     (mod_r)
  );

  initial mod_clk = 1'b0;
  always #5 mod_clk = ~mod_clk;

  initial edge_n = 0;
  always @(posedge mod_clk) edge_n++;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2*W-1:0] x,
                                 input logic [W-1:0] n,
                                 input int e0);
    exp_t e;
    e.e0 = e0;
    if (n == '0) begin
      e.r = '0;
      e.err = 1'b1;
      e.lat = 0;
    end else begin
      e.r = W'(x % {{W{1'b0}}, n});
      e.err = 1'b0;
      e.lat = 2 * W;
`ifdef RSA_MOD_FAST_EN
      if (x[2*W-1:W] == '0 && x[W-1:0] < n) e.lat = 0;
`endif
    end
    return e;
  endfunction

  always @(negedge mod_clk) begin
    if (mod_done && !mod_rst) begin
      if (q.size() == 0) begin
        check("spurious_done", 32'(mod_done), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("r", 32'(mod_r), 32'(e.r));
        check("err", 32'(mod_err), 32'(e.err));
        check("lat", 32'(edge_n - e.e0), 32'(e.lat));
        check("busy_at_done", 32'(mod_busy), 32'd0);
      end
    end
  end

  task automatic start_req(input logic [2*W-1:0] x, input logic [W-1:0] n);
    mod_start = 1'b1;
    mod_x     = x;
    mod_n     = n;
    q.push_back(model(x, n, edge_n + 1));
    @(posedge mod_clk);
    #1 mod_start = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (q.size() != 0 && k < 40) begin
      @(negedge mod_clk);
      #1;
      k++;
    end
    check("timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    mod_rst   = 1'b1;
    mod_start = 1'b0;
    mod_x     = '0;
    mod_n     = '0;
    repeat (3) @(negedge mod_clk);
    check("rst_busy", 32'(mod_busy), 32'd0);
    check("rst_done", 32'(mod_done), 32'd0);
    check("rst_err", 32'(mod_err), 32'd0);
    check("rst_r", 32'(mod_r), 32'd0);
    mod_rst = 1'b0;
    @(negedge mod_clk);
    #1;

    start_req(16'h1234, 8'hF1);
`ifndef RSA_MOD_FAST_EN
    for (int i = 1; i < 2 * W; i++) begin
      @(negedge mod_clk);
      check("run_busy", 32'(mod_busy), 32'd1);
    end
`endif
    wait_idle();

    start_req(16'hFFFF, 8'hFF);
    wait_idle();
    start_req(16'hFFFE, 8'hFF);
    @(negedge mod_clk);
    check("b2b_busy", 32'(mod_busy), 32'd1);
    wait_idle();

    @(negedge mod_clk);
    #1;
    start_req(16'h0005, 8'h07);
    wait_idle();

    @(negedge mod_clk);
    #1;
    start_req(16'h1234, 8'h00);
    check("nzero_busy", 32'(mod_busy), 32'd0);
    wait_idle();
    check("nzero_busy2", 32'(mod_busy), 32'd0);

    @(negedge mod_clk);
    #1;
    start_req(16'h1234, 8'hF1);
    repeat (4) @(posedge mod_clk);
    #1;
    mod_start = 1'b1;
    mod_x     = 16'h0001;
    mod_n     = 8'h03;
    @(posedge mod_clk);
    #1 mod_start = 1'b0;
    wait_idle();

    @(negedge mod_clk);
    #1;
    start_req(16'h1234, 8'hF1);
    repeat (8) @(posedge mod_clk);
    #3 mod_rst = 1'b1;
    #1;
    check("arst_busy", 32'(mod_busy), 32'd0);
    check("arst_done", 32'(mod_done), 32'd0);
    check("arst_r", 32'(mod_r), 32'd0);
    q.delete();
    repeat (2) @(negedge mod_clk);
    mod_rst = 1'b0;
    repeat (20) @(negedge mod_clk);
    #1;
    start_req(16'h00FF, 8'h10);
    wait_idle();

    for (int i = 0; i < 6; i++) begin
      logic [2*W-1:0] x;
      logic [W-1:0]   n;
      x = 16'($urandom_range(0, 65535));
      n = 8'($urandom_range(1, 255));
      if (i == 0) x = {8'h00, 8'(n - 8'd1)};
      @(negedge mod_clk);
      #1;
      start_req(x, n);
      wait_idle();
    end

    repeat (3) @(negedge mod_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
